// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode encodings, flag bit positions, branch condition
//             codes and branch-FSM state encoding for the ALU writeback stage.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcodes, identical to the ALU result selector encodings
    localparam logic [3:0] c_OP_NOPA = 4'd0;
    localparam logic [3:0] c_OP_NOPB = 4'd1;
    localparam logic [3:0] c_OP_NOTA = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_XOR  = 4'd5;
    localparam logic [3:0] c_OP_ADD  = 4'd6;
    localparam logic [3:0] c_OP_SUB  = 4'd7;
    localparam logic [3:0] c_OP_MUL  = 4'd8;
    localparam logic [3:0] c_OP_DIV  = 4'd9;
    localparam logic [3:0] c_OP_MOD  = 4'd10;
    localparam logic [3:0] c_OP_CLRC = 4'd11;
    localparam logic [3:0] c_OP_SETC = 4'd12;

    // Flag bit positions inside the {N,Z,V,C} register
    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_V = 1;
    localparam int c_FLAG_C = 0;

    // Branch condition codes; 13..15 are never taken
    localparam logic [3:0] c_CC_AL = 4'd0;
    localparam logic [3:0] c_CC_EQ = 4'd1;
    localparam logic [3:0] c_CC_NE = 4'd2;
    localparam logic [3:0] c_CC_CS = 4'd3;
    localparam logic [3:0] c_CC_CC = 4'd4;
    localparam logic [3:0] c_CC_MI = 4'd5;
    localparam logic [3:0] c_CC_PL = 4'd6;
    localparam logic [3:0] c_CC_VS = 4'd7;
    localparam logic [3:0] c_CC_VC = 4'd8;
    localparam logic [3:0] c_CC_GE = 4'd9;
    localparam logic [3:0] c_CC_LT = 4'd10;
    localparam logic [3:0] c_CC_GT = 4'd11;
    localparam logic [3:0] c_CC_LE = 4'd12;

    // Branch FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } br_state_t;

    // True when the condition code is satisfied by the given flags
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic v;
        logic c;
        logic res;
        n = f[c_FLAG_N];
        z = f[c_FLAG_Z];
        v = f[c_FLAG_V];
        c = f[c_FLAG_C];
        res = 1'b0;
        case (cond)
            c_CC_AL: res = 1'b1;
            c_CC_EQ: res = z;
            c_CC_NE: res = !z;
            c_CC_CS: res = c;
            c_CC_CC: res = !c;
            c_CC_MI: res = n;
            c_CC_PL: res = !n;
            c_CC_VS: res = v;
            c_CC_VC: res = !v;
            c_CC_GE: res = (n == v);
            c_CC_LT: res = (n != v);
            c_CC_GT: res = !z && (n == v);
            c_CC_LE: res = z || (n != v);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_wb_ccr_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_wb_ccr_if
//  Purpose  : Bundles the ALU result input, register-file writeback output,
//             committed flags and branch request/ack signals.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_wb_ccr_if #(
    parameter int DATA_W = 16,
    parameter int DST_W  = 4
);
    logic                     alu_valid;
    logic                     alu_ready;
    logic [3:0]               alu_op;
    logic signed [DATA_W-1:0] alu_c;
    logic [3:0]               alu_ccr;
    logic [DST_W-1:0]         alu_dst;
    logic                     wb_valid;
    logic                     wb_ready;
    logic [DATA_W-1:0]        wb_data;
    logic [DST_W-1:0]         wb_dst;
    logic [3:0]               flags;
    logic                     br_req;
    logic [3:0]               br_cond;
    logic                     br_ack;
    logic                     br_taken;

    // Producer/consumer environment side
    modport master (
        output alu_valid, alu_op, alu_c, alu_ccr, alu_dst, wb_ready, br_req, br_cond,
        input  alu_ready, wb_valid, wb_data, wb_dst, flags, br_ack, br_taken
    );

    // Writeback stage side
    modport slave (
        input  alu_valid, alu_op, alu_c, alu_ccr, alu_dst, wb_ready, br_req, br_cond,
        output alu_ready, wb_valid, wb_data, wb_dst, flags, br_ack, br_taken
    );
endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : DEPTH-entry synchronous FIFO holding results headed for the
//             register file. Head entry is presented directly; reads as zero
//             while empty.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 20
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int              c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule
`default_nettype wire

// File: rtl/alu_wb_ccr.sv
`default_nettype none
// ============================================================================
//  Module   : alu_wb_ccr
//  Purpose  : ALU result consumer: maintains the committed N/Z/V/C flags,
//             buffers results toward the register file and resolves
//             conditional-branch requests against the committed flags.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_wb_ccr
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DST_W  = 4,
    parameter int DEPTH  = 2
) (
    input wire logic   clk,
    input wire logic   rst,
    alu_wb_ccr_if.slave bus
);
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [DATA_W+DST_W-1:0] w_head;
    logic [3:0]              r_flags;
    br_state_t               r_state;
    logic [3:0]              r_cond;
    logic                    r_br_ack;
    logic                    r_br_taken;

    assign w_accept = bus.alu_valid && bus.alu_ready;
    // Flag-only ops and unused opcodes produce no register write
    assign w_push   = w_accept && (bus.alu_op <= c_OP_MOD);
    assign w_pop    = !w_empty && bus.wb_ready;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + DST_W)
    ) u_wb_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({bus.alu_c, bus.alu_dst}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.alu_ready = !w_full;
    assign bus.wb_valid  = !w_empty;
    assign bus.wb_data   = w_head[DATA_W+DST_W-1:DST_W];
    assign bus.wb_dst    = w_head[DST_W-1:0];
    assign bus.flags     = r_flags;
    assign bus.br_ack    = r_br_ack;
    assign bus.br_taken  = r_br_taken;

    // Commit flags from each accepted ALU result according to its opcode class
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else if (w_accept) begin
            case (bus.alu_op)
                c_OP_ADD, c_OP_SUB: begin
                    r_flags <= bus.alu_ccr;
                end
                c_OP_NOPA, c_OP_NOPB, c_OP_NOTA, c_OP_AND, c_OP_OR, c_OP_XOR,
                c_OP_MUL, c_OP_DIV, c_OP_MOD: begin
                    r_flags[c_FLAG_N] <= bus.alu_ccr[c_FLAG_N];
                    r_flags[c_FLAG_Z] <= bus.alu_ccr[c_FLAG_Z];
                end
                c_OP_CLRC: r_flags[c_FLAG_C] <= 1'b0;
                c_OP_SETC: r_flags[c_FLAG_C] <= 1'b1;
                default:   r_flags <= r_flags;
            endcase
        end
    end

    // Branch resolution: latch the condition, evaluate one cycle later so a
    // same-cycle flag update is seen, then wait for the request to drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cond     <= 4'd0;
            r_br_ack   <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_br_ack   <= 1'b0;
            r_br_taken <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.br_req) begin
                        r_cond  <= bus.br_cond;
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_br_ack   <= 1'b1;
                    r_br_taken <= cond_met(r_cond, r_flags);
                    r_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!bus.br_req) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_wb_ccr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_wb_ccr
//  Purpose  : Self-checking bench for alu_wb_ccr: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a queue-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_wb_ccr;
    localparam int DATA_W = 16;
    localparam int DST_W  = 4;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   run_cmp = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_wb_ccr_if #(.DATA_W(DATA_W), .DST_W(DST_W)) bus_if ();

    alu_wb_ccr #(.DATA_W(DATA_W), .DST_W(DST_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [DST_W-1:0]  dst;
    } ent_t;

    ent_t       m_q[$];
    logic [3:0] m_flags;
    int         m_phase;      // 0 free, 1 request latched, 2 acked/awaiting release
    logic [3:0] m_cond;
    bit         m_ack;
    bit         m_taken;

    function automatic bit model_taken(input int cond, input logic [3:0] f);
        bit n, z, v, c;
        {n, z, v, c} = f;
        case (cond)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return c;
            4:  return !c;
            5:  return n;
            6:  return !n;
            7:  return v;
            8:  return !v;
            9:  return n == v;
            10: return n != v;
            11: return !z && (n == v);
            12: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    // Model advances on each clock edge from the inputs presented in that cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_flags = 4'b0;
            m_phase = 0;
            m_cond  = 4'd0;
            m_ack   = 1'b0;
            m_taken = 1'b0;
        end else begin
            bit acc;
            int op;
            acc = bus_if.alu_valid && (m_q.size() < DEPTH);
            op  = int'(bus_if.alu_op);
            // branch sees flags as they were before this edge's update
            m_ack   = 1'b0;
            m_taken = 1'b0;
            if (m_phase == 1) begin
                m_ack   = 1'b1;
                m_taken = model_taken(int'(m_cond), m_flags);
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (!bus_if.br_req) m_phase = 0;
            end else if (bus_if.br_req) begin
                m_cond  = bus_if.br_cond;
                m_phase = 1;
            end
            if (m_q.size() != 0 && bus_if.wb_ready) void'(m_q.pop_front());
            if (acc) begin
                if (op <= 10) m_q.push_back('{d: bus_if.alu_c, dst: bus_if.alu_dst});
                if (op == 6 || op == 7) m_flags = bus_if.alu_ccr;
                else if (op <= 10) m_flags[3:2] = bus_if.alu_ccr[3:2];
                else if (op == 11) m_flags[0] = 1'b0;
                else if (op == 12) m_flags[0] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            check("m_alu_ready", 32'(bus_if.alu_ready), 32'(m_q.size() < DEPTH));
            check("m_wb_valid", 32'(bus_if.wb_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("m_wb_data", 32'(bus_if.wb_data), 32'(m_q[0].d));
                check("m_wb_dst", 32'(bus_if.wb_dst), 32'(m_q[0].dst));
            end
            check("m_flags", 32'(bus_if.flags), 32'(m_flags));
            check("m_br_ack", 32'(bus_if.br_ack), 32'(m_ack));
            if (m_ack) check("m_br_taken", 32'(bus_if.br_taken), 32'(m_taken));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send_alu(input logic [3:0] op, input logic [15:0] c,
                            input logic [3:0] ccr, input logic [3:0] dst);
        bus_if.alu_valid = 1'b1;
        bus_if.alu_op    = op;
        bus_if.alu_c     = c;
        bus_if.alu_ccr   = ccr;
        bus_if.alu_dst   = dst;
        next_edge();
        bus_if.alu_valid = 1'b0;
    endtask

    task automatic do_branch(input logic [3:0] cond, input bit exp_taken, input string name);
        bus_if.br_req  = 1'b1;
        bus_if.br_cond = cond;
        next_edge();
        @(negedge clk);
        check({name, "_ack_early"}, 32'(bus_if.br_ack), 32'd0);
        next_edge();
        @(negedge clk);
        check({name, "_ack"}, 32'(bus_if.br_ack), 32'd1);
        check({name, "_taken"}, 32'(bus_if.br_taken), 32'(exp_taken));
        bus_if.br_req = 1'b0;
        next_edge();
        @(negedge clk);
        check({name, "_ack_after"}, 32'(bus_if.br_ack), 32'd0);
    endtask

    initial begin
        int  acks;
        bit  acked;
        bus_if.alu_valid = 1'b0;
        bus_if.alu_op    = 4'd0;
        bus_if.alu_c     = '0;
        bus_if.alu_ccr   = 4'd0;
        bus_if.alu_dst   = '0;
        bus_if.wb_ready  = 1'b1;
        bus_if.br_req    = 1'b0;
        bus_if.br_cond   = 4'd0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_alu_ready", 32'(bus_if.alu_ready), 32'd1);
        check("rst_wb_valid", 32'(bus_if.wb_valid), 32'd0);
        check("rst_wb_data", 32'(bus_if.wb_data), 32'd0);
        check("rst_flags", 32'(bus_if.flags), 32'd0);
        check("rst_br_ack", 32'(bus_if.br_ack), 32'd0);
        rst = 1'b0;
        run_cmp = 1'b1;
        next_edge();

        // ADD writes all flags, result visible one cycle after accept
        send_alu(4'd6, 16'h0000, 4'b0111, 4'd3);
        @(negedge clk);
        check("add_flags", 32'(bus_if.flags), 32'h7);
        check("add_wb_valid", 32'(bus_if.wb_valid), 32'd1);
        check("add_wb_data", 32'(bus_if.wb_data), 32'h0000);
        check("add_wb_dst", 32'(bus_if.wb_dst), 32'd3);
        next_edge();

        // logic op keeps V,C; CLRC/SETC touch only C and push nothing
        send_alu(4'd6, 16'h0005, 4'b0011, 4'd1);
        @(negedge clk);
        check("add2_flags", 32'(bus_if.flags), 32'b0011);
        send_alu(4'd3, 16'h8000, 4'b1000, 4'd2);
        @(negedge clk);
        check("and_flags", 32'(bus_if.flags), 32'b1011);
        check("and_wb_data", 32'(bus_if.wb_data), 32'h8000);
        send_alu(4'd11, 16'h1234, 4'b0101, 4'd4);
        @(negedge clk);
        check("clrc_flags", 32'(bus_if.flags), 32'b1010);
        check("clrc_no_push", 32'(bus_if.wb_valid), 32'd0);
        send_alu(4'd12, 16'h1234, 4'b0100, 4'd4);
        @(negedge clk);
        check("setc_flags", 32'(bus_if.flags), 32'b1011);
        check("setc_no_push", 32'(bus_if.wb_valid), 32'd0);
        send_alu(4'd11, 16'h1234, 4'b0000, 4'd4);
        @(negedge clk);
        check("clrc2_flags", 32'(bus_if.flags), 32'b1010);
        send_alu(4'd14, 16'h4321, 4'b1111, 4'd5);
        @(negedge clk);
        check("op14_flags", 32'(bus_if.flags), 32'b1010);
        check("op14_no_push", 32'(bus_if.wb_valid), 32'd0);

        // backpressure: two entries fill the buffer, third is refused
        bus_if.wb_ready = 1'b0;
        send_alu(4'd0, 16'h1111, 4'b0000, 4'd6);
        send_alu(4'd0, 16'h2222, 4'b0000, 4'd7);
        @(negedge clk);
        check("bp_full_ready", 32'(bus_if.alu_ready), 32'd0);
        check("bp_head0", 32'(bus_if.wb_data), 32'h1111);
        send_alu(4'd0, 16'h3333, 4'b0000, 4'd8);
        @(negedge clk);
        check("bp_refused_ready", 32'(bus_if.alu_ready), 32'd0);
        check("bp_refused_head", 32'(bus_if.wb_data), 32'h1111);
        bus_if.wb_ready = 1'b1;
        next_edge();
        @(negedge clk);
        check("bp_pop1_data", 32'(bus_if.wb_data), 32'h2222);
        check("bp_pop1_dst", 32'(bus_if.wb_dst), 32'd7);
        check("bp_pop1_ready", 32'(bus_if.alu_ready), 32'd1);
        next_edge();
        @(negedge clk);
        check("bp_drained", 32'(bus_if.wb_valid), 32'd0);

        // branches against flags N=1 only
        send_alu(4'd6, 16'h0001, 4'b1000, 4'd1);
        @(negedge clk);
        check("br_setup_flags", 32'(bus_if.flags), 32'b1000);
        do_branch(4'd10, 1'b1, "br_lt");
        do_branch(4'd9, 1'b0, "br_ge");
        do_branch(4'd14, 1'b0, "br_never");
        do_branch(4'd12, 1'b1, "br_le");

        // request held for several cycles yields a single ack
        acks = 0;
        bus_if.br_req  = 1'b1;
        bus_if.br_cond = 4'd0;
        repeat (6) begin
            next_edge();
            @(negedge clk);
            if (bus_if.br_ack) acks++;
        end
        bus_if.br_req = 1'b0;
        repeat (2) begin
            next_edge();
            @(negedge clk);
            if (bus_if.br_ack) acks++;
        end
        check("br_hold_single_ack", 32'(acks), 32'd1);

        // flag update accepted in the same cycle the request is sampled
        next_edge();
        bus_if.br_req  = 1'b1;
        bus_if.br_cond = 4'd1;
        send_alu(4'd7, 16'h0000, 4'b0100, 4'd2);
        @(negedge clk);
        check("hz_flags", 32'(bus_if.flags), 32'b0100);
        next_edge();
        @(negedge clk);
        check("hz_ack", 32'(bus_if.br_ack), 32'd1);
        check("hz_taken", 32'(bus_if.br_taken), 32'd1);
        bus_if.br_req = 1'b0;
        repeat (2) next_edge();

        // randomized traffic, checked every cycle by the model
        acked = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus_if.alu_valid = ($urandom_range(0, 3) != 0);
            bus_if.alu_op    = 4'($urandom_range(0, 15));
            bus_if.alu_c     = 16'($urandom);
            bus_if.alu_ccr   = 4'($urandom);
            bus_if.alu_dst   = 4'($urandom);
            bus_if.wb_ready  = ($urandom_range(0, 9) < 6);
            if (!bus_if.br_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus_if.br_req  = 1'b1;
                    bus_if.br_cond = 4'($urandom);
                    acked = 1'b0;
                end
            end else begin
                if (bus_if.br_ack) acked = 1'b1;
                if (acked && $urandom_range(0, 1) == 0) bus_if.br_req = 1'b0;
            end
            next_edge();
        end

        // settle, then reset with two buffered entries and a branch in flight
        bus_if.alu_valid = 1'b0;
        bus_if.br_req    = 1'b0;
        bus_if.wb_ready  = 1'b1;
        repeat (4) next_edge();
        bus_if.wb_ready = 1'b0;
        send_alu(4'd6, 16'hAAAA, 4'b1111, 4'd1);
        bus_if.br_req  = 1'b1;
        bus_if.br_cond = 4'd0;
        send_alu(4'd6, 16'hBBBB, 4'b1111, 4'd2);
        #1;
        check("pre_rst_flags", 32'(bus_if.flags), 32'hF);
        check("pre_rst_ready", 32'(bus_if.alu_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_wb_valid", 32'(bus_if.wb_valid), 32'd0);
        check("async_rst_flags", 32'(bus_if.flags), 32'd0);
        check("async_rst_ready", 32'(bus_if.alu_ready), 32'd1);
        check("async_rst_ack", 32'(bus_if.br_ack), 32'd0);
        bus_if.br_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.br_ack) acks++;
        end
        check("post_rst_no_ack", 32'(acks), 32'd0);
        check("post_rst_wb_valid", 32'(bus_if.wb_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
